decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue_pkg.sv | 20 ++
 rtl/decode_issue_regfile.sv | 35 +++
 rtl/decode_issue.sv | 102 ++++++++++
 tb/tb_decode_issue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - shared opcode header: ALU opcodes and default widths
package decode_issue_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG_DEF   = 8;
    localparam int OP_W       = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SLL = 4'h5,
        OP_SRL = 4'h6,
        OP_SRA = 4'h7,
        OP_SLT = 4'h8
    } alu_op_e;

endpackage

// File: rtl/decode_issue_regfile.sv
// rtl/decode_issue_regfile.sv - register file, two async reads, one sync write, r0 hardwired to zero
import decode_issue_pkg::*;

module regfile #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - operand fetch with EX/WB forwarding and a single-entry issue register
import decode_issue_pkg::*;

module decode_issue #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic [AW-1:0]            in_rd,
    input  logic [AW-1:0]            in_rs1,
    input  logic [AW-1:0]            in_rs2,
    input  logic [DATA_W-1:0]        in_imm,
    input  logic                     in_use_imm,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     ex_fwd_en,
    input  logic [AW-1:0]            ex_fwd_addr,
    input  logic [DATA_W-1:0]        ex_fwd_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] operand_a,
    output logic signed [DATA_W-1:0] operand_b,
    output logic [OP_W-1:0]          alu_op,
    output logic [AW-1:0]            out_rd
);

    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] op_a_d, op_b_d;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [AW-1:0]     out_rd_q;
    logic              out_valid_q, out_valid_d;
    logic              accept;

    regfile #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (in_rs1),
        .rdata_a_o (rf_a),
        .raddr_b_i (in_rs2),
        .rdata_b_o (rf_b)
    );

    // The EX result is younger than the WB result, so it wins when both target the same register.
    function automatic logic [DATA_W-1:0] resolve(input logic [AW-1:0] rs, input logic [DATA_W-1:0] rf_val);
        if (rs == '0)                             return '0;
        else if (ex_fwd_en && ex_fwd_addr == rs)  return ex_fwd_data;
        else if (wb_en && wb_addr == rs)          return wb_data;
        else                                      return rf_val;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_a_d      = resolve(in_rs1, rf_a);
        op_b_d      = in_use_imm ? in_imm : resolve(in_rs2, rf_b);
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            alu_op_q    <= '0;
            out_rd_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept && !flush) begin
                op_a_q   <= op_a_d;
                op_b_q   <= op_b_d;
                alu_op_q <= in_op;
                out_rd_q <= in_rd;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign operand_a = op_a_q;
    assign operand_b = op_b_q;
    assign alu_op    = alu_op_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - table-driven bench for decode_issue
import decode_issue_pkg::*;

module tb_decode_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_ready, in_use_imm, wb_en, ex_fwd_en, flush;
    logic               out_valid, out_ready;
    logic [3:0]         in_op, alu_op;
    logic [2:0]         in_rd, in_rs1, in_rs2, wb_addr, ex_fwd_addr, out_rd;
    logic [15:0]        in_imm, wb_data, ex_fwd_data;
    logic signed [15:0] operand_a, operand_b;

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op), .out_rd(out_rd)
    );

    typedef struct {
        logic        rst, in_valid;
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic        use_imm, wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic        fwd_en;
        logic [2:0]  fwd_addr;
        logic [15:0] fwd_data;
        logic        flush, out_ready;
        logic        chk_rdy, e_rdy, e_vld;
        logic [15:0] e_a, e_b;
        logic [3:0]  e_op;
        logic [2:0]  e_rd;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t idle(input logic ordy);
        vec_t t;
        t = '{rst: 1'b0, in_valid: 1'b0, op: 4'h0, rd: 3'd0, rs1: 3'd0, rs2: 3'd0, imm: 16'h0,
              use_imm: 1'b0, wb_en: 1'b0, wb_addr: 3'd0, wb_data: 16'h0, fwd_en: 1'b0,
              fwd_addr: 3'd0, fwd_data: 16'h0, flush: 1'b0, out_ready: ordy,
              chk_rdy: 1'b0, e_rdy: 1'b0, e_vld: 1'b0, e_a: 16'h0, e_b: 16'h0, e_op: 4'h0, e_rd: 3'd0};
        return t;
    endfunction

    function automatic vec_t ins(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, input logic ordy);
        vec_t t;
        t = idle(ordy);
        t.in_valid = 1'b1; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        return t;
    endfunction

    function automatic vec_t wb(input vec_t t, input logic [2:0] a, input logic [15:0] d);
        vec_t r;
        r = t; r.wb_en = 1'b1; r.wb_addr = a; r.wb_data = d;
        return r;
    endfunction

    function automatic vec_t fw(input vec_t t, input logic [2:0] a, input logic [15:0] d);
        vec_t r;
        r = t; r.fwd_en = 1'b1; r.fwd_addr = a; r.fwd_data = d;
        return r;
    endfunction

    function automatic vec_t ex(input vec_t t, input logic crdy, rdy, vld, input logic [15:0] a, b,
                                input logic [3:0] op, input logic [2:0] rd);
        vec_t r;
        r = t; r.chk_rdy = crdy; r.e_rdy = rdy; r.e_vld = vld;
        r.e_a = a; r.e_b = b; r.e_op = op; r.e_rd = rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; in_valid = t.in_valid; in_op = t.op; in_rd = t.rd;
        in_rs1 = t.rs1; in_rs2 = t.rs2; in_imm = t.imm; in_use_imm = t.use_imm;
        wb_en = t.wb_en; wb_addr = t.wb_addr; wb_data = t.wb_data;
        ex_fwd_en = t.fwd_en; ex_fwd_addr = t.fwd_addr; ex_fwd_data = t.fwd_data;
        flush = t.flush; out_ready = t.out_ready;
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t);
        #1;
        if (t.chk_rdy) chk({tag, " in_ready"}, 32'(in_ready), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(t.e_vld));
        chk({tag, " operand_a"}, 32'($unsigned(operand_a)), 32'(t.e_a));
        chk({tag, " operand_b"}, 32'($unsigned(operand_b)), 32'(t.e_b));
        chk({tag, " alu_op"}, 32'(alu_op), 32'(t.e_op));
        chk({tag, " out_rd"}, 32'(out_rd), 32'(t.e_rd));
    endtask

    initial begin
        vec_t t;
        drive(idle(1'b1));

        // reset and basic issue
        t = idle(1'b1); t.rst = 1'b1;
        vq.push_back(ex(t, 0, 0, 0, 16'h0, 16'h0, 4'h0, 3'd0));
        vq.push_back(ex(idle(1'b1), 1, 1, 0, 16'h0, 16'h0, 4'h0, 3'd0));
        vq.push_back(ex(wb(idle(1'b1), 3'd1, 16'h0005), 1, 1, 0, 16'h0, 16'h0, 4'h0, 3'd0));
        vq.push_back(ex(ins(OP_ADD, 3'd3, 3'd1, 3'd1, 1'b1), 1, 1, 1, 16'h5, 16'h5, OP_ADD, 3'd3));
        // forwarding priority
        vq.push_back(ex(wb(idle(1'b1), 3'd2, 16'h0010), 1, 1, 0, 16'h5, 16'h5, OP_ADD, 3'd3));
        vq.push_back(ex(wb(ins(OP_SUB, 3'd4, 3'd2, 3'd0, 1'b1), 3'd2, 16'h0020), 1, 1, 1, 16'h20, 16'h0, OP_SUB, 3'd4));
        vq.push_back(ex(fw(wb(ins(OP_OR, 3'd5, 3'd2, 3'd0, 1'b1), 3'd2, 16'h0020), 3'd2, 16'h0030),
                        1, 1, 1, 16'h30, 16'h0, OP_OR, 3'd5));
        vq.push_back(ex(ins(OP_AND, 3'd6, 3'd2, 3'd0, 1'b1), 1, 1, 1, 16'h20, 16'h0, OP_AND, 3'd6));
        vq.push_back(ex(fw(ins(OP_XOR, 3'd7, 3'd2, 3'd3, 1'b1), 3'd3, 16'h0077), 1, 1, 1, 16'h20, 16'h77, OP_XOR, 3'd7));
        vq.push_back(ex(fw(ins(OP_SLT, 3'd1, 3'd0, 3'd2, 1'b1), 3'd0, 16'h0099), 1, 1, 1, 16'h0, 16'h20, OP_SLT, 3'd1));
        // r0 write ignored, immediate bypasses forwarding
        vq.push_back(ex(wb(idle(1'b1), 3'd0, 16'hFFFF), 1, 1, 0, 16'h0, 16'h20, OP_SLT, 3'd1));
        t = fw(ins(OP_AND, 3'd1, 3'd0, 3'd2, 1'b1), 3'd2, 16'h0055); t.use_imm = 1'b1; t.imm = 16'h8000;
        vq.push_back(ex(t, 1, 1, 1, 16'h0, 16'h8000, OP_AND, 3'd1));
        // stall for three cycles, then release
        for (int i = 0; i < 3; i++)
            vq.push_back(ex(ins(OP_ADD, 3'd2, 3'd1, 3'd2, 1'b0), 1, 0, 1, 16'h0, 16'h8000, OP_AND, 3'd1));
        vq.push_back(ex(ins(OP_ADD, 3'd2, 3'd1, 3'd2, 1'b1), 1, 1, 1, 16'h5, 16'h20, OP_ADD, 3'd2));
        vq.push_back(ex(idle(1'b1), 1, 1, 0, 16'h5, 16'h20, OP_ADD, 3'd2));
        // flush discards the accept but the writeback still lands
        t = wb(ins(OP_SUB, 3'd6, 3'd1, 3'd1, 1'b1), 3'd3, 16'h0042); t.flush = 1'b1;
        vq.push_back(ex(t, 1, 1, 0, 16'h5, 16'h20, OP_ADD, 3'd2));
        vq.push_back(ex(ins(OP_OR, 3'd3, 3'd3, 3'd0, 1'b1), 1, 1, 1, 16'h42, 16'h0, OP_OR, 3'd3));
        vq.push_back(ex(idle(1'b0), 1, 0, 1, 16'h42, 16'h0, OP_OR, 3'd3));
        t = idle(1'b0); t.flush = 1'b1;
        vq.push_back(ex(t, 1, 0, 0, 16'h42, 16'h0, OP_OR, 3'd3));
        // reset in the middle of a stall beats a simultaneous writeback
        vq.push_back(ex(ins(OP_ADD, 3'd4, 3'd1, 3'd3, 1'b1), 1, 1, 1, 16'h5, 16'h42, OP_ADD, 3'd4));
        vq.push_back(ex(idle(1'b0), 1, 0, 1, 16'h5, 16'h42, OP_ADD, 3'd4));
        t = wb(idle(1'b0), 3'd5, 16'h0033); t.rst = 1'b1;
        vq.push_back(ex(t, 1, 0, 0, 16'h0, 16'h0, 4'h0, 3'd0));
        vq.push_back(ex(ins(OP_ADD, 3'd1, 3'd1, 3'd2, 1'b1), 1, 1, 1, 16'h0, 16'h0, OP_ADD, 3'd1));
        vq.push_back(ex(ins(OP_SUB, 3'd2, 3'd3, 3'd5, 1'b1), 1, 1, 1, 16'h0, 16'h0, OP_SUB, 3'd2));

        foreach (vq[i]) apply(vq[i], $sformatf("v%0d", i));

        // every register reads back zero after the mid-stall reset
        for (int r = 1; r < 8; r++)
            apply(ex(ins(OP_ADD, 3'(r), 3'(r), 3'(r), 1'b1), 1, 1, 1, 16'h0, 16'h0, OP_ADD, 3'(r)),
                  $sformatf("rd_r%0d", r));

        // writeback commits while the issue register is stalled
        apply(ex(ins(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1), 1, 1, 1, 16'h0, 16'h0, OP_ADD, 3'd7), "s0");
        apply(ex(wb(ins(OP_SUB, 3'd5, 3'd6, 3'd0, 1'b0), 3'd6, 16'hABCD), 1, 0, 1, 16'h0, 16'h0, OP_ADD, 3'd7), "s1");
        apply(ex(ins(OP_SUB, 3'd5, 3'd6, 3'd0, 1'b1), 1, 1, 1, 16'hABCD, 16'h0, OP_SUB, 3'd5), "s2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
